ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Upstream controller for the 32x32 single-port RAM (clk write, comb read gated by ena && !wena, 'z' otherwise).
//  Turns the RAM into a circular FIFO: push/pop request-ack interface toward the datapath, drives RAM ena/wena/addr/data_in.
//  One RAM access per cycle; pop has priority over push. Read data captured into a register, presented one cycle after pop_ack.
// PARAMETERS
//  DATA_W  32  word width; equals RAM data width
//  ADDR_W  5   RAM address width
//  DEPTH   32  FIFO capacity in words; must equal 2**ADDR_W
// PORTS
//  clk        in   1         system clock, all state on rising edge
//  rst        in   1         asynchronous, active-high reset
//  push       in   1         request to write push_data
//  push_data  in   DATA_W    word to enqueue
//  push_ack   out  1         comb: push accepted this cycle
//  pop        in   1         request to dequeue one word
//  pop_ack    out  1         comb: pop accepted this cycle
//  pop_data   out  DATA_W    registered dequeued word
//  pop_valid  out  1         1-cycle pulse: pop_data updated
//  full       out  1         count == DEPTH
//  empty      out  1         count == 0
//  count      out  ADDR_W+1  words stored, 0..DEPTH
//  ram_ena    out  1         to RAM ena
//  ram_wena   out  1         to RAM wena
//  ram_addr   out  ADDR_W    to RAM addr
//  ram_wdata  out  DATA_W    to RAM data_in
//  ram_rdata  in   DATA_W    from RAM data_out
// BEHAVIOUR
//  - Reset (async, while rst=1): wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, pop_data=0; push_ack=pop_ack=0, ram_ena=0, ram_wena=0. RAM contents not cleared.
//  - Grant (comb): pop_ack = pop & ~empty; push_ack = push & ~full & ~pop_ack.
//  - RAM drive (comb): pop_ack -> ena=1, wena=0, addr=rd_ptr; else push_ack -> ena=1, wena=1, addr=wr_ptr;
//    else ena=0, wena=0, addr=wr_ptr. ram_wdata = push_data always.
//  - Edge with pop_ack: pop_data <= ram_rdata; rd_ptr <= rd_ptr+1; pop_valid <= 1. Otherwise pop_valid <= 0, pop_data holds.
//  - Edge with push_ack: RAM stores push_data at wr_ptr (same edge); wr_ptr <= wr_ptr+1.
//  - count: +1 on push_ack, -1 on pop_ack; never both in one cycle. full/empty decoded from the count register.
//  - Latency: push visible to pop on the next cycle (count>0). pop_ack cycle N -> pop_data/pop_valid valid cycle N+1.
//  - Pointers are ADDR_W bits, wrap mod DEPTH (31 -> 0) without stall.
//  - Empty + push + pop: pop refused, push accepted. Full + push + pop: pop accepted, push refused; push retries next cycle.
//  - Non-empty, not full + push + pop: pop wins, push_ack=0 (requester holds push).
//  - Push when full / pop when empty: ack=0, no state change, RAM idle (ena=0).
//  - Reset mid-operation: state cleared immediately; in-flight pop_valid dropped; a write on the edge coincident with rst is not guaranteed.
// CONFIGURATION
//  RAM_FIFO_ERR_EN defined: adds outputs overflow, underflow (1 bit each, reset 0, sticky until rst).
//    overflow sets on edge with push & full; underflow on edge with pop & empty.
//  Not defined: ports absent; refused requests are silent.
// TESTING
//  - rst pulse mid-cycle -> all outputs at reset values immediately; empty=1, count=0, ram_ena=0.
//  - 32 pushes 0x1000_0000..0x1000_001F -> each push_ack=1, ram_wena=1, addr 0..31; then full=1, count=32; 33rd push_ack=0.
//  - Pop 32 times -> pop_data 0x1000_0000..0x1000_001F in order, each 1 cycle after pop_ack; empty=1; 33rd pop_ack=0.
//  - Wrap: push 20, pop 20, push 20 -> wr_ptr wraps 31->0 at 12th push; pops return same 20 words in order.
//  - count=5, push&pop same cycle -> pop_ack=1, push_ack=0, ram_wena=0, count=4; held push acked next cycle, count=5.
//  - ERR_EN: pop while empty -> underflow=1 and stays 1 through later valid ops until rst; push while full -> overflow=1.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push/pop handshake plus RAM bus of the FIFO controller.
// master = datapath/RAM side, slave = controller; overflow/underflow under RAM_FIFO_ERR_EN.
interface ram_fifo_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_ack;
  logic              pop;
  logic              pop_ack;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ram_ena;
  logic              ram_wena;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef RAM_FIFO_ERR_EN
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output push, push_data, pop, ram_rdata,
    input  push_ack, pop_ack, pop_data,
    input  pop_valid, full, empty, count,
    input  ram_ena, ram_wena, ram_addr, ram_wdata
`ifdef RAM_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  push, push_data, pop, ram_rdata,
    output push_ack, pop_ack, pop_data,
    output pop_valid, full, empty, count,
    output ram_ena, ram_wena, ram_addr, ram_wdata
`ifdef RAM_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: circular FIFO over a single-port RAM (pop beats push).
// Ports: clk, rst (async high), bus (ram_fifo_ctrl_if.slave). Option: RAM_FIFO_ERR_EN.
module ram_fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input logic              clk,
  input logic              rst,
  ram_fifo_ctrl_if.slave   bus
);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              full, empty;
  logic              push_ack, pop_ack;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

  // rst gating keeps both acks low while reset is held
  always_comb begin
    pop_ack  = bus.pop & ~empty & ~rst;
    push_ack = bus.push & ~full & ~pop_ack & ~rst;
  end

  always_comb begin
    bus.ram_ena  = 1'b0;
    bus.ram_wena = 1'b0;
    bus.ram_addr = wr_ptr_q;
    unique case (1'b1)
      pop_ack: begin
        bus.ram_ena  = 1'b1;
        bus.ram_addr = rd_ptr_q;
      end
      push_ack: begin
        bus.ram_ena  = 1'b1;
        bus.ram_wena = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_ack;
    pop_data_d  = pop_data_q;
    if (push_ack) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ack) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      pop_data_d = bus.ram_rdata;
    end
    // acks are mutually exclusive
    unique case (1'b1)
      pop_ack:  count_d = count_q - 1'b1;
      push_ack: count_d = count_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign bus.push_ack  = push_ack;
  assign bus.pop_ack   = pop_ack;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.ram_wdata = bus.push_data;

`ifdef RAM_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // sticky until reset
  always_comb begin
    overflow_d  = overflow_q | (bus.push & full);
    underflow_d = underflow_q | (bus.pop & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed bench for ram_fifo_ctrl with a 32x32 RAM model.
// Checks reset, fill/drain, wrap, arbitration, mid-op reset, error flags.
module tb_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  ram_fifo_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [32];

  always @(posedge clk)
    if (bus.ram_ena && bus.ram_wena)
      mem[bus.ram_addr] <= bus.ram_wdata;

  assign bus.ram_rdata =
    (bus.ram_ena && !bus.ram_wena) ? mem[bus.ram_addr] : 'x;

  task automatic idle();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.push      = 1'b1;
      bus.push_data = base + 32'(i);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    bus.push = 1'b1;
    bus.push_data = 32'hdead_beef;
    bus.pop = 1'b1;
    rst = 1'b1;
    #3;
    tests++;
    if (bus.count !== 6'd0 || bus.empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_cnt: count=%0d empty=%b want 0/1",
               bus.count, bus.empty);
    end
    tests++;
    if (bus.push_ack !== 1'b0 || bus.pop_ack !== 1'b0 ||
        bus.ram_ena !== 1'b0 || bus.ram_wena !== 1'b0) begin
      fails++;
      $display("FAIL reset_ack: pa=%b qa=%b ena=%b wena=%b want 0",
               bus.push_ack, bus.pop_ack, bus.ram_ena, bus.ram_wena);
    end
    tests++;
    if (bus.pop_valid !== 1'b0 || bus.pop_data !== 32'd0 ||
        bus.full !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: pv=%b pd=%h full=%b want 0",
               bus.pop_valid, bus.pop_data, bus.full);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.push      = 1'b1;
      bus.push_data = 32'h1000_0000 + 32'(i);
      #1;
      tests++;
      if (bus.push_ack !== 1'b1 || bus.ram_ena !== 1'b1 ||
          bus.ram_wena !== 1'b1 || bus.ram_addr !== 5'(i)) begin
        fails++;
        $display("FAIL fill_%0d: pa=%b ena=%b wena=%b addr=%0d want 1/1/1/%0d",
                 i, bus.push_ack, bus.ram_ena, bus.ram_wena,
                 bus.ram_addr, i);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.count !== 6'(i + 1)) begin
        fails++;
        $display("FAIL fill_cnt_%0d: count=%0d want %0d",
                 i, bus.count, i + 1);
      end
    end
    tests++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      fails++;
      $display("FAIL full_flag: full=%b empty=%b want 1/0",
               bus.full, bus.empty);
    end
    @(negedge clk);
    bus.push_data = 32'h2222_2222;
    #1;
    tests++;
    if (bus.push_ack !== 1'b0 || bus.ram_ena !== 1'b0) begin
      fails++;
      $display("FAIL push_full: pa=%b ena=%b want 0/0",
               bus.push_ack, bus.ram_ena);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.count !== 6'd32) begin
      fails++;
      $display("FAIL push_full_cnt: count=%0d want 32", bus.count);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.pop = 1'b1;
      #1;
      tests++;
      if (bus.pop_ack !== 1'b1 || bus.ram_ena !== 1'b1 ||
          bus.ram_wena !== 1'b0 || bus.ram_addr !== 5'(i)) begin
        fails++;
        $display("FAIL drain_%0d: qa=%b ena=%b wena=%b addr=%0d want 1/1/0/%0d",
                 i, bus.pop_ack, bus.ram_ena, bus.ram_wena,
                 bus.ram_addr, i);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.pop_valid !== 1'b1 ||
          bus.pop_data !== 32'h1000_0000 + 32'(i)) begin
        fails++;
        $display("FAIL drain_data_%0d: pv=%b pd=%h want 1/%h",
                 i, bus.pop_valid, bus.pop_data,
                 32'h1000_0000 + 32'(i));
      end
    end
    tests++;
    if (bus.empty !== 1'b1 || bus.count !== 6'd0) begin
      fails++;
      $display("FAIL drain_empty: empty=%b count=%0d want 1/0",
               bus.empty, bus.count);
    end
    @(negedge clk);
    #1;
    tests++;
    if (bus.pop_ack !== 1'b0 || bus.ram_ena !== 1'b0) begin
      fails++;
      $display("FAIL pop_empty: qa=%b ena=%b want 0/0",
               bus.pop_ack, bus.ram_ena);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.pop_valid !== 1'b0 || bus.pop_data !== 32'h1000_001f) begin
      fails++;
      $display("FAIL pop_empty_hold: pv=%b pd=%h want 0/1000001f",
               bus.pop_valid, bus.pop_data);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    do_reset();
    fill(20, 32'ha000_0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.pop = 1'b1;
    end
    @(negedge clk);
    idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.push      = 1'b1;
      bus.push_data = 32'hb000_0000 + 32'(i);
      #1;
      tests++;
      if (bus.push_ack !== 1'b1 ||
          bus.ram_addr !== 5'((20 + i) % 32)) begin
        fails++;
        $display("FAIL wrap_push_%0d: pa=%b addr=%0d want 1/%0d",
                 i, bus.push_ack, bus.ram_addr, (20 + i) % 32);
      end
    end
    @(negedge clk);
    idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.pop = 1'b1;
      @(posedge clk);
      #1;
      exp = 32'hb000_0000 + 32'(i);
      tests++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp) begin
        fails++;
        $display("FAIL wrap_pop_%0d: pv=%b pd=%h want 1/%h",
                 i, bus.pop_valid, bus.pop_data, exp);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_arbitration();
    do_reset();
    @(negedge clk);
    bus.push      = 1'b1;
    bus.pop       = 1'b1;
    bus.push_data = 32'hc000_0000;
    #1;
    tests++;
    if (bus.pop_ack !== 1'b0 || bus.push_ack !== 1'b1) begin
      fails++;
      $display("FAIL arb_empty: qa=%b pa=%b want 0/1",
               bus.pop_ack, bus.push_ack);
    end
    @(negedge clk);
    idle();
    do_reset();
    fill(5, 32'hd000_0000);
    @(negedge clk);
    bus.push      = 1'b1;
    bus.pop       = 1'b1;
    bus.push_data = 32'he000_0005;
    #1;
    tests++;
    if (bus.pop_ack !== 1'b1 || bus.push_ack !== 1'b0 ||
        bus.ram_wena !== 1'b0) begin
      fails++;
      $display("FAIL arb_mid: qa=%b pa=%b wena=%b want 1/0/0",
               bus.pop_ack, bus.push_ack, bus.ram_wena);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.count !== 6'd4 || bus.pop_data !== 32'hd000_0000) begin
      fails++;
      $display("FAIL arb_mid_cnt: count=%0d pd=%h want 4/d0000000",
               bus.count, bus.pop_data);
    end
    @(negedge clk);
    bus.pop = 1'b0;
    #1;
    tests++;
    if (bus.push_ack !== 1'b1 || bus.ram_addr !== 5'd5) begin
      fails++;
      $display("FAIL arb_retry: pa=%b addr=%0d want 1/5",
               bus.push_ack, bus.ram_addr);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.count !== 6'd5) begin
      fails++;
      $display("FAIL arb_retry_cnt: count=%0d want 5", bus.count);
    end
    @(negedge clk);
    idle();
    do_reset();
    fill(32, 32'hf000_0000);
    @(negedge clk);
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    #1;
    tests++;
    if (bus.pop_ack !== 1'b1 || bus.push_ack !== 1'b0) begin
      fails++;
      $display("FAIL arb_full: qa=%b pa=%b want 1/0",
               bus.pop_ack, bus.push_ack);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.count !== 6'd31 || bus.pop_data !== 32'hf000_0000) begin
      fails++;
      $display("FAIL arb_full_cnt: count=%0d pd=%h want 31/f0000000",
               bus.count, bus.pop_data);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill(3, 32'h5000_0000);
    @(negedge clk);
    bus.pop = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.pop_valid !== 1'b1) begin
      fails++;
      $display("FAIL mrst_pre: pv=%b want 1", bus.pop_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.pop_valid !== 1'b0 || bus.count !== 6'd0 ||
        bus.empty !== 1'b1 || bus.ram_ena !== 1'b0 ||
        bus.pop_data !== 32'd0) begin
      fails++;
      $display("FAIL mrst: pv=%b cnt=%0d empty=%b ena=%b pd=%h want 0/0/1/0/0",
               bus.pop_valid, bus.count, bus.empty,
               bus.ram_ena, bus.pop_data);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
  endtask

`ifdef RAM_FIFO_ERR_EN
  task automatic test_err();
    do_reset();
    @(negedge clk);
    bus.pop = 1'b1;
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
      fails++;
      $display("FAIL err_udf: udf=%b ovf=%b want 1/0",
               bus.underflow, bus.overflow);
    end
    fill(1, 32'h7);
    @(negedge clk);
    bus.pop = 1'b1;
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.underflow !== 1'b1) begin
      fails++;
      $display("FAIL err_udf_sticky: udf=%b want 1", bus.underflow);
    end
    fill(32, 32'h8000_0000);
    @(negedge clk);
    bus.push = 1'b1;
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.overflow !== 1'b1) begin
      fails++;
      $display("FAIL err_ovf: ovf=%b want 1", bus.overflow);
    end
    do_reset();
    #1;
    tests++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      fails++;
      $display("FAIL err_rst: ovf=%b udf=%b want 0/0",
               bus.overflow, bus.underflow);
    end
  endtask
`endif

  initial begin
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_arbitration();
    test_mid_reset();
`ifdef RAM_FIFO_ERR_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
